// File: rtl/vga_if.sv
// VGA timing bundle shared by the draw chain: master drives timing plus colour,
// slave consumes the timing fields only.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/draw_bg_stars.sv
// Background stage: base colour plus a hashed, vertically scrolling, twinkling star
// field. Timing fields pass through with a 2-cycle delay aligned to rgb.
module draw_bg_stars #(
   parameter int          V_ACTIVE     = 600,
   parameter int          SCROLL_DIV   = 4,
   parameter logic [7:0]  STAR_DENSITY = 8'd6,
   parameter logic [31:0] SEED         = 32'h1234ABCD,
   parameter int          FRAME_W      = 8,
   parameter int          TWINKLE_BIT  = 3
) (
   input  logic        clk,
   input  logic        rst,
   vga_if.slave        vga_in,
   vga_if.master       vga_out,
   input  logic [11:0] bg_color,
   input  logic [11:0] star_color,
   input  logic        scroll_en
);

   localparam logic [31:0] HASH_MUL = 32'h045D9F3B;
   localparam logic [11:0] V_ACT12  = 12'(V_ACTIVE);
   localparam logic [10:0] V_LAST   = 11'(V_ACTIVE - 1);

   logic               vblnk_d;
   logic [FRAME_W-1:0] frame_cnt;
   logic [10:0]        scroll_off;
   logic [11:0]        bg_sh;
   logic [11:0]        star_sh;

   logic        fs;
   logic        scroll_step;
   logic [11:0] y_sum;
   logic [10:0] y_wrap;
   logic [31:0] key_next;

   assign fs          = vga_in.vblnk && !vblnk_d;
   assign scroll_step = (int'(frame_cnt) % SCROLL_DIV) == (SCROLL_DIV - 1);
   // Both addends are below V_ACTIVE in the active area, so one subtract wraps.
   assign y_sum       = {1'b0, vga_in.vcount} + {1'b0, scroll_off};
   assign y_wrap      = (y_sum >= V_ACT12) ? 11'(y_sum - V_ACT12) : y_sum[10:0];
   assign key_next    = {10'b0, y_wrap, vga_in.hcount} ^ SEED;

   // Frame-synchronous state: counter, scroll offset and colour shadows.
   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_d    <= 1'b0;
         frame_cnt  <= '0;
         scroll_off <= '0;
         bg_sh      <= 12'h00F;
         star_sh    <= 12'hFFF;
      end else begin
         vblnk_d <= vga_in.vblnk;
         if (fs) begin
            frame_cnt <= frame_cnt + 1'b1;
            bg_sh     <= bg_color;
            star_sh   <= star_color;
            if (scroll_en && scroll_step)
               scroll_off <= (scroll_off == V_LAST) ? 11'd0 : scroll_off + 11'd1;
         end
      end
   end

   logic [10:0] h1, v1;
   logic        hs1, vs1, hb1, vb1, blank1;
   logic [31:0] key1;

   always_ff @(posedge clk) begin
      if (rst) begin
         h1     <= '0;
         v1     <= '0;
         hs1    <= 1'b0;
         vs1    <= 1'b0;
         hb1    <= 1'b0;
         vb1    <= 1'b0;
         blank1 <= 1'b0;
         key1   <= '0;
      end else begin
         h1     <= vga_in.hcount;
         v1     <= vga_in.vcount;
         hs1    <= vga_in.hsync;
         vs1    <= vga_in.vsync;
         hb1    <= vga_in.hblnk;
         vb1    <= vga_in.vblnk;
         blank1 <= vga_in.hblnk || vga_in.vblnk;
         key1   <= key_next;
      end
   end

   // Only product bits [31:23] matter: hash8 on top, twinkle select just below.
   logic [8:0]  m_top;
   logic        star;
   logic        tw;
   logic [11:0] star_dim;
   logic [11:0] rgb_next;

   assign m_top    = 9'((key1 * HASH_MUL) >> 23);
   assign star     = m_top[8:1] < STAR_DENSITY;
   assign tw       = m_top[0] && frame_cnt[TWINKLE_BIT];
   assign star_dim = {1'b0, star_sh[11:9], 1'b0, star_sh[7:5], 1'b0, star_sh[3:1]};

   always_comb begin
      rgb_next = bg_sh;
      if (blank1)
         rgb_next = 12'h000;
      else if (star)
         rgb_next = tw ? star_dim : star_sh;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vga_out.hcount <= '0;
         vga_out.vcount <= '0;
         vga_out.hsync  <= 1'b0;
         vga_out.vsync  <= 1'b0;
         vga_out.hblnk  <= 1'b0;
         vga_out.vblnk  <= 1'b0;
         vga_out.rgb    <= '0;
      end else begin
         vga_out.hcount <= h1;
         vga_out.vcount <= v1;
         vga_out.hsync  <= hs1;
         vga_out.vsync  <= vs1;
         vga_out.hblnk  <= hb1;
         vga_out.vblnk  <= vb1;
         vga_out.rgb    <= rgb_next;
      end
   end

endmodule

// File: tb/tb_draw_bg_stars.sv
// Bench for draw_bg_stars: small raster, random colours and scroll enables,
// every output pixel checked against a frame-level reference model.
module tb_draw_bg_stars;

   localparam int          H_ACT  = 16;
   localparam int          H_TOT  = 20;
   localparam int          V_ACT  = 12;
   localparam int          V_TOT  = 15;
   localparam int          SDIV   = 2;
   localparam logic [7:0]  DENS   = 8'd80;
   localparam logic [31:0] SEED   = 32'h1234ABCD;
   localparam int          FW     = 4;
   localparam int          TWB    = 2;
   localparam int          FRAMES = 60;
   localparam int          W      = 38;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vga_if vin ();
   vga_if vout ();
   logic [11:0] bg_color, star_color;
   logic        scroll_en;

   draw_bg_stars #(
      .V_ACTIVE(V_ACT), .SCROLL_DIV(SDIV), .STAR_DENSITY(DENS),
      .SEED(SEED), .FRAME_W(FW), .TWINKLE_BIT(TWB)
   ) dut (
      .clk(clk), .rst(rst), .vga_in(vin.slave), .vga_out(vout.master),
      .bg_color(bg_color), .star_color(star_color), .scroll_en(scroll_en)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (at %0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_fc, m_scroll;
   logic [11:0] m_bg, m_st;
   logic        m_vb_d;

   function automatic logic [11:0] ref_rgb(input int h, input int y, input logic blank,
                                           input int fc, input logic [11:0] bg,
                                           input logic [11:0] st);
      logic [31:0] key;
      logic [63:0] prod;
      logic [31:0] m;
      logic [11:0] r;
      key  = ({10'b0, 11'(y), 11'(h)}) ^ SEED;
      prod = 64'(key) * 64'(32'h045D9F3B);
      m    = prod[31:0];
      if (blank) return 12'h000;
      if (m[31:24] >= DENS) return bg;
      if (m[23] && ((fc >> TWB) & 1) == 1) begin
         for (int i = 0; i < 3; i++) r[i*4 +: 4] = st[i*4 +: 4] >> 1;
         return r;
      end
      return st;
   endfunction

   function automatic logic [W-1:0] observed();
      return {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
              vout.hblnk, vout.vblnk, vout.rgb};
   endfunction

   // ---------------- driver ----------------
   task automatic step(input int h, input int v, input logic r);
      logic hs, vs, hb, vb, fs;
      int   y;
      logic [11:0] rgb;
      @(negedge clk);
      if (exp_q.size() == 2) check("pix", observed(), exp_q.pop_front());
      if ($urandom_range(0, 39) == 0) bg_color   = 12'($urandom);
      if ($urandom_range(0, 39) == 0) star_color = 12'($urandom);
      hb = (h >= H_ACT);
      vb = (v >= V_ACT);
      hs = (h >= 17 && h <= 18);
      vs = (v == 13);
      rst = r;
      vin.hcount = 11'(h);
      vin.vcount = 11'(v);
      vin.hsync  = hs;
      vin.vsync  = vs;
      vin.hblnk  = hb;
      vin.vblnk  = vb;
      if (r) begin
         m_fc = 0; m_scroll = 0; m_bg = 12'h00F; m_st = 12'hFFF; m_vb_d = 1'b0;
         exp_q.push_back('0);
      end else begin
         y  = (v + m_scroll) % V_ACT;
         fs = vb && !m_vb_d;
         m_vb_d = vb;
         if (fs) begin
            if (scroll_en && (m_fc % SDIV) == SDIV - 1) m_scroll = (m_scroll + 1) % V_ACT;
            m_fc = (m_fc + 1) % (1 << FW);
            m_bg = bg_color;
            m_st = star_color;
         end
         rgb = ref_rgb(h, y, hb || vb, m_fc, m_bg, m_st);
         exp_q.push_back({11'(h), 11'(v), hs, vs, hb, vb, rgb});
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      bg_color = 12'h123; star_color = 12'h456; scroll_en = 1'b1;
      vin.hcount = '0; vin.vcount = '0;
      vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;

      for (int i = 0; i < 4; i++)
         step($urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1), 1'b1);
      // The last reset-cycle slot leaves the pipeline with a cleared key, which hashes
      // to 0 (a star, no twinkle) against the reset star shadow.
      exp_q[exp_q.size() - 1] = {26'b0, 12'hFFF};

      for (int f = 0; f < FRAMES; f++) begin
         if (f >= 20 && f <= 26) scroll_en = 1'b0;
         else                    scroll_en = ($urandom_range(0, 4) != 0);
         for (int v = 0; v < V_TOT; v++)
            for (int h = 0; h < H_TOT; h++)
               step(h, v, 1'b0);
      end
      step(H_ACT, V_ACT, 1'b0);
      step(H_ACT, V_ACT, 1'b0);
      step(H_ACT, V_ACT, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
